// File: rtl/mult_pkg.sv
// Shared definitions for the serial multiplier sequencer.
// Contents: 3-bit FSM state encoding, default operand width, product width,
// default watchdog limit, product-shifter load hold length, and a helper
// that sizes counters.
package mult_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SHIFT_IN = 3'd1,
    ST_MUL_GO   = 3'd2,
    ST_MUL_WAIT = 3'd3,
    ST_OUT_REQ  = 3'd4,
    ST_OUT_HI   = 3'd5,
    ST_OUT_LO   = 3'd6,
    ST_FIN      = 3'd7
  } state_t;

  localparam int unsigned DEF_OPW = 12;
  localparam int unsigned DEF_PW  = 2 * DEF_OPW;
  localparam int unsigned DEF_TMO = 63;
  localparam int unsigned SZ_HOLD = 2;

  // Width of a counter that must reach n-1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Watchdog cycle counter for the multiplier sequencer.
// Ports:
//   clk    - clock
//   reset  - asynchronous active-low reset
//   en     - sequencer is in a state that is being timed
//   clr    - sequencer changes state this cycle (restart the count)
//   expire - high in the TMO-th consecutive timed cycle
module seq_watchdog
  import mult_pkg::*;
#(
  parameter int unsigned TMO = DEF_TMO
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic expire
);

  localparam int unsigned WW = cnt_width(TMO);
  localparam logic [WW-1:0] LAST = WW'(TMO - 1);

  logic [WW-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr || !en) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign expire = en && (count == LAST);

endmodule

// File: rtl/mult_sequencer.sv
// Top-level controller for the serial unsigned multiplier: shifts operands in,
// starts the core, waits for its result, triggers the product shifter and
// waits for it to drain.
// Optional feature macro: MULT_SEQ_TIMEOUT_EN (watchdog on the wait states).
// Ports:
//   clk       - clock
//   reset     - asynchronous active-low reset
//   start     - transaction request, sampled only in IDLE
//   sin_en    - operand shift-register enable (OPW cycles)
//   mul_start - one-cycle multiplier start pulse
//   mul_done  - multiplier result-valid level
//   sz        - product shifter load request (SZ_HOLD cycles)
//   fz        - product shifter busy flag
//   busy      - high outside IDLE
//   done      - one-cycle completion pulse
//   err       - one-cycle watchdog expiry pulse (0 without the feature)
module mult_sequencer
  import mult_pkg::*;
#(
  parameter int unsigned OPW = DEF_OPW,
  parameter int unsigned TMO = DEF_TMO
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic sin_en,
  output logic mul_start,
  input  logic mul_done,
  output logic sz,
  input  logic fz,
  output logic busy,
  output logic done,
  output logic err
);

  localparam int unsigned CW = cnt_width((OPW > SZ_HOLD) ? OPW : SZ_HOLD);
  localparam logic [CW-1:0] OPW_LAST = CW'(OPW - 1);
  localparam logic [CW-1:0] SZ_LAST  = CW'(SZ_HOLD - 1);

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          err_next;
  logic          wd_en;
  logic          wd_expire;

  assign wd_en = (state == ST_MUL_WAIT) || (state == ST_OUT_HI) ||
                 (state == ST_OUT_LO);

  always_comb begin
    state_next = state;
    cnt_next   = '0;
    err_next   = 1'b0;
    case (state)
      ST_IDLE:     if (start) state_next = ST_SHIFT_IN;
      ST_SHIFT_IN: if (cnt == OPW_LAST) state_next = ST_MUL_GO;
      ST_MUL_GO:   state_next = ST_MUL_WAIT;
      ST_MUL_WAIT: if (mul_done) state_next = ST_OUT_REQ;
      ST_OUT_REQ:  if (cnt == SZ_LAST) state_next = ST_OUT_HI;
      ST_OUT_HI:   if (fz) state_next = ST_OUT_LO;
      ST_OUT_LO:   if (!fz) state_next = ST_FIN;
      ST_FIN:      state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
`ifdef MULT_SEQ_TIMEOUT_EN
    // Expiry overrides any progress made in the same cycle.
    if (wd_expire) begin
      state_next = ST_IDLE;
      err_next   = 1'b1;
    end
`endif
    // The counter restarts from 0 on every state change.
    if ((state_next == state) &&
        ((state == ST_SHIFT_IN) || (state == ST_OUT_REQ))) begin
      cnt_next = cnt + 1'b1;
    end
  end

`ifdef MULT_SEQ_TIMEOUT_EN
  seq_watchdog #(
    .TMO(TMO)
  ) u_watchdog (
    .clk   (clk),
    .reset (reset),
    .en    (wd_en),
    .clr   (state_next != state),
    .expire(wd_expire)
  );
`else
  logic unused_wd;
  assign wd_expire = 1'b0;
  assign unused_wd = wd_en ^ wd_expire ^ (^TMO);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Outputs are registered from the next-state decode so each one is high
  // exactly while the FSM occupies the corresponding state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sin_en    <= 1'b0;
      mul_start <= 1'b0;
      sz        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      sin_en    <= (state_next == ST_SHIFT_IN);
      mul_start <= (state_next == ST_MUL_GO);
      sz        <= (state_next == ST_OUT_REQ);
      busy      <= (state_next != ST_IDLE);
      done      <= (state_next == ST_FIN);
      err       <= err_next;
    end
  end

endmodule
